time_entry: RTL and testbench

- Keypad-side writer for the microwave countdown timer chain.
- Collects BCD digits typed on the keypad into an MM:SS buffer and validates the value on start.
- Drives the timer digits' parallel-load interface (data + active-low loadn), then holds the count enable until the timer reports zero.
- Sits between the keypad scanner and the timer digit counters (mod10/mod6 chain).

---
 rtl/time_entry.sv | 156 +++++++++++++++
 tb/tb_time_entry.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_entry.sv
// Keypad-side writer for the microwave countdown timer: collects MM:SS BCD digits,
// validates on start, parallel-loads the timer digits and enables counting until zero.
module time_entry #(
  parameter int LOAD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  key_digit,
  input  logic        key_valid,
  input  logic        key_start,
  input  logic        key_clear,
  input  logic        timer_zero,
  output logic [15:0] load_data,
  output logic        loadn,
  output logic        run_en,
  output logic        done,
  output logic        entry_err,
  output logic [2:0]  digit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);

  state_t      state_r, state_s;
  logic [15:0] buf_r, buf_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [1:0]  lcnt_r, lcnt_s;
  logic        first_r, first_s;
  logic        loadn_r, loadn_s;
  logic        run_r, run_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic        start_bad_s;
  logic        digit_bad_s;

  // A start is refused for an empty entry, an all-zero time, or seconds tens above 5.
  always_comb begin
    start_bad_s = (cnt_r == 3'd0) || (buf_r == 16'h0000) || (buf_r[7:4] > 4'd5);
    digit_bad_s = (key_digit > 4'd9) || (cnt_r == 3'd4);
  end

  // Next-state and next-output decode; strobes default low, loadn defaults high.
  always_comb begin
    state_s = state_r;
    buf_s   = buf_r;
    cnt_s   = cnt_r;
    lcnt_s  = lcnt_r;
    first_s = first_r;
    loadn_s = 1'b1;
    run_s   = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    if (key_clear) begin
      state_s = IDLE;
      buf_s   = 16'h0000;
      cnt_s   = 3'd0;
      lcnt_s  = 2'd0;
      first_s = 1'b0;
    end else begin
      case (state_r)
        IDLE, ENTRY: begin
          // A start wins over a same-cycle digit, which is then dropped silently.
          if (key_start) begin
            if (start_bad_s) begin
              err_s = 1'b1;
            end else begin
              state_s = LOAD;
              loadn_s = 1'b0;
              lcnt_s  = 2'd0;
            end
          end else if (key_valid) begin
            if (digit_bad_s) begin
              err_s = 1'b1;
            end else begin
              buf_s   = {buf_r[11:0], key_digit};
              cnt_s   = cnt_r + 3'd1;
              state_s = ENTRY;
            end
          end else begin
            state_s = state_r;
          end
        end
        LOAD: begin
          if (lcnt_r == LOAD_LAST) begin
            state_s = RUN;
            run_s   = 1'b1;
            first_s = 1'b1;
          end else begin
            lcnt_s  = lcnt_r + 2'd1;
            loadn_s = 1'b0;
          end
        end
        RUN: begin
          // The first run cycle masks timer_zero left over from the previous count.
          if (first_r) begin
            first_s = 1'b0;
            run_s   = 1'b1;
          end else if (timer_zero) begin
            state_s = IDLE;
            buf_s   = 16'h0000;
            cnt_s   = 3'd0;
            done_s  = 1'b1;
          end else begin
            run_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          buf_s   = 16'h0000;
          cnt_s   = 3'd0;
          lcnt_s  = 2'd0;
          first_s = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= IDLE;
      buf_r   <= 16'h0000;
      cnt_r   <= 3'd0;
      lcnt_r  <= 2'd0;
      first_r <= 1'b0;
      loadn_r <= 1'b1;
      run_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      buf_r   <= buf_s;
      cnt_r   <= cnt_s;
      lcnt_r  <= lcnt_s;
      first_r <= first_s;
      loadn_r <= loadn_s;
      run_r   <= run_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign load_data = buf_r;
  assign loadn     = loadn_r;
  assign run_en    = run_r;
  assign done      = done_r;
  assign entry_err = err_r;
  assign digit_cnt = cnt_r;

endmodule

// File: tb/tb_time_entry.sv
// Scoreboard bench for time_entry: instance a uses LOAD_CYCLES=1, instance b LOAD_CYCLES=3.
module tb_time_entry;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  cnt;
    logic        loadn;
    logic        run_en;
    logic        done;
    logic        err;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr_a = 1'b0, kv_a = 1'b0, ks_a = 1'b0, kc_a = 1'b0, tz_a = 1'b0;
  logic [3:0]  kd_a = 4'd0;
  logic [15:0] ld_a;
  logic        loadn_a, run_a, done_a, err_a;
  logic [2:0]  cnt_a;

  logic        clr_b = 1'b0, kv_b = 1'b0, ks_b = 1'b0, kc_b = 1'b0, tz_b = 1'b0;
  logic [3:0]  kd_b = 4'd0;
  logic [15:0] ld_b;
  logic        loadn_b, run_b, done_b, err_b;
  logic [2:0]  cnt_b;

  time_entry #(.LOAD_CYCLES(1)) dut_a (
    .clk(clk), .clr(clr_a), .key_digit(kd_a), .key_valid(kv_a), .key_start(ks_a),
    .key_clear(kc_a), .timer_zero(tz_a), .load_data(ld_a), .loadn(loadn_a),
    .run_en(run_a), .done(done_a), .entry_err(err_a), .digit_cnt(cnt_a)
  );

  time_entry #(.LOAD_CYCLES(3)) dut_b (
    .clk(clk), .clr(clr_b), .key_digit(kd_b), .key_valid(kv_b), .key_start(ks_b),
    .key_clear(kc_b), .timer_zero(tz_b), .load_data(ld_b), .loadn(loadn_b),
    .run_en(run_b), .done(done_b), .entry_err(err_b), .digit_cnt(cnt_b)
  );

  out_t exp_q[$];
  out_t obs_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic out_t o(input logic [15:0] d, input logic [2:0] c, input logic ln,
                             input logic r, input logic dn, input logic e);
    out_t v;
    v.data = d; v.cnt = c; v.loadn = ln; v.run_en = r; v.done = dn; v.err = e;
    return v;
  endfunction

  function automatic string fmt(input out_t v);
    return $sformatf("data=%h cnt=%0d loadn=%b run_en=%b done=%b err=%b",
                     v.data, v.cnt, v.loadn, v.run_en, v.done, v.err);
  endfunction

  // One clock of stimulus on the chosen instance; expectation queued, output captured after the edge.
  task automatic drv(input bit sel, input logic c, input logic kv, input logic [3:0] kd,
                     input logic ks, input logic kc, input logic tz, input out_t e);
    if (sel) begin
      clr_b = c; kv_b = kv; kd_b = kd; ks_b = ks; kc_b = kc; tz_b = tz;
    end else begin
      clr_a = c; kv_a = kv; kd_a = kd; ks_a = ks; kc_a = kc; tz_a = tz;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (sel) obs_q.push_back({ld_b, cnt_b, loadn_b, run_b, done_b, err_b});
    else     obs_q.push_back({ld_a, cnt_a, loadn_a, run_a, done_a, err_a});
    clr_a = 1'b0; kv_a = 1'b0; kd_a = 4'd0; ks_a = 1'b0; kc_a = 1'b0; tz_a = 1'b0;
    clr_b = 1'b0; kv_b = 1'b0; kd_b = 4'd0; ks_b = 1'b0; kc_b = 1'b0; tz_b = 1'b0;
  endtask

  task automatic key(input bit s, input logic [3:0] d, input out_t e);
    drv(s, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, e);
  endtask
  task automatic start(input bit s, input out_t e);
    drv(s, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, e);
  endtask
  task automatic start_key(input bit s, input logic [3:0] d, input out_t e);
    drv(s, 1'b0, 1'b1, d, 1'b1, 1'b0, 1'b0, e);
  endtask
  task automatic clear(input bit s, input out_t e);
    drv(s, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, e);
  endtask
  task automatic idle(input bit s, input out_t e);
    drv(s, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e);
  endtask
  task automatic zero(input bit s, input out_t e);
    drv(s, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, e);
  endtask
  task automatic rst(input bit s, input out_t e);
    drv(s, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic test_reset();
    out_t e, g;
    rst(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    rst(1'b1, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL reset step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_countdown();
    out_t e, g;
    key(1'b0, 4'd1, o(16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd3, o(16'h0013, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd0, o(16'h0130, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b0, o(16'h0130, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
    zero(1'b0, o(16'h0130, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    zero(1'b0, o(16'h0130, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) idle(1'b0, o(16'h0130, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0));
    zero(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    idle(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL countdown step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_seconds();
    out_t e, g;
    clear(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd9, o(16'h0009, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd9, o(16'h0099, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd7, o(16'h0997, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd5, o(16'h9975, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b0, o(16'h9975, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
    idle(1'b0, o(16'h9975, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL bad_seconds step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    out_t e, g;
    clear(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd1, o(16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd2, o(16'h0012, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd3, o(16'h0123, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd4, o(16'h1234, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd5, o(16'h1234, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1));
    idle(1'b0, o(16'h1234, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    clear(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'hB, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    idle(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL overflow step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_empty_start();
    out_t e, g;
    start(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    key(1'b0, 4'd0, o(16'h0000, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd0, o(16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b0, o(16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1));
    start_key(1'b0, 4'd5, o(16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1));
    idle(1'b0, o(16'h0000, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL empty_start step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    out_t e, g;
    clear(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd5, o(16'h0005, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd9, o(16'h0059, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    start_key(1'b0, 4'd7, o(16'h0059, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b0, o(16'h0059, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    start_key(1'b0, 4'd3, o(16'h0059, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    start_key(1'b0, 4'hA, o(16'h0059, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    key(1'b0, 4'd1, o(16'h0059, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0));
    clear(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b0, 4'd4, o(16'h0004, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b0, o(16'h0004, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b0, o(16'h0004, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    idle(1'b0, o(16'h0004, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    rst(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(1'b0, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL back_to_back step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_load3();
    out_t e, g;
    key(1'b1, 4'd1, o(16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b1, o(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    zero(1'b1, o(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    key(1'b1, 4'd2, o(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b1, o(16'h0001, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0));
    clear(1'b1, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    key(1'b1, 4'd1, o(16'h0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    start(1'b1, o(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(1'b1, o(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    clear(1'b1, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(1'b1, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(1'b1, o(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = obs_q.pop_front(); total_cnt++;
      if (g !== e) $display("FAIL load3 step %0d: got %s, want %s", i, fmt(g), fmt(e));
      else pass_cnt++;
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_countdown();
    test_bad_seconds();
    test_overflow();
    test_empty_start();
    test_back_to_back();
    test_load3();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
